// File: rtl/boolean_sweep_ctrl.sv
// Self-test sequencer: sweeps all 16 operand vectors into two 4-input boolean
// function units, captures their truth tables and compares them to latched masks.
module boolean_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] exp_f1,
  input  logic [15:0] exp_f2,
  input  logic        f1_in,
  input  logic        f2_in,
  output logic        a_out,
  output logic        b_out,
  output logic        c_out,
  output logic        d_out,
  output logic        w_out,
  output logic        x_out,
  output logic        y_out,
  output logic        z_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_f1,
  output logic [15:0] tt_f2,
  output logic [4:0]  err_cnt1,
  output logic [4:0]  err_cnt2,
  output logic        pass,
  output logic [3:0]  fail_idx,
  output logic        fail_valid
);

  localparam int unsigned IW = 4;
  localparam int unsigned TW = 16;
  localparam int unsigned CW = 5;
  localparam logic [IW-1:0] SETTLE_LAST = IW'(SETTLE_CYCLES);
  localparam logic [IW-1:0] IDX_LAST    = IW'(TW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [IW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] ops, ops_nxt;
  logic [TW-1:0] exp1, exp1_nxt, exp2, exp2_nxt;
  logic [TW-1:0] tt1_nxt, tt2_nxt;
  logic [TW-1:0] diff1, diff2, diff_any;
  logic [CW-1:0] err1_nxt, err2_nxt;
  logic [IW-1:0] fidx_nxt;
  logic          pass_nxt, fvalid_nxt, done_nxt, busy_nxt;

  // Next-state, sweep bookkeeping and result computation.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    exp1_nxt   = exp1;
    exp2_nxt   = exp2;
    tt1_nxt    = tt_f1;
    tt2_nxt    = tt_f2;
    err1_nxt   = err_cnt1;
    err2_nxt   = err_cnt2;
    pass_nxt   = pass;
    fidx_nxt   = fail_idx;
    fvalid_nxt = fail_valid;
    done_nxt   = 1'b0;
    diff1      = '0;
    diff2      = '0;
    diff_any   = '0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt  = S_RUN;
          exp1_nxt   = exp_f1;
          exp2_nxt   = exp_f2;
          tt1_nxt    = '0;
          tt2_nxt    = '0;
          err1_nxt   = '0;
          err2_nxt   = '0;
          pass_nxt   = 1'b0;
          fidx_nxt   = '0;
          fvalid_nxt = 1'b0;
          idx_nxt    = '0;
          cnt_nxt    = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt  = S_IDLE;
          tt1_nxt    = '0;
          tt2_nxt    = '0;
          err1_nxt   = '0;
          err2_nxt   = '0;
          pass_nxt   = 1'b0;
          fidx_nxt   = '0;
          fvalid_nxt = 1'b0;
          idx_nxt    = '0;
          cnt_nxt    = '0;
        end else if (cnt == SETTLE_LAST) begin
          tt1_nxt[idx] = f1_in;
          tt2_nxt[idx] = f2_in;
          cnt_nxt      = '0;
          idx_nxt      = IW'(idx + IW'(1));
          if (idx == IDX_LAST) begin
            // Last sample: results are formed from the just-completed tables.
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
            diff1     = tt1_nxt ^ exp1;
            diff2     = tt2_nxt ^ exp2;
            diff_any  = diff1 | diff2;
            err1_nxt  = '0;
            err2_nxt  = '0;
            for (int i = 0; i < int'(TW); i++) begin
              err1_nxt = CW'(err1_nxt + CW'(diff1[i]));
              err2_nxt = CW'(err2_nxt + CW'(diff2[i]));
            end
            fidx_nxt = '0;
            for (int i = int'(TW) - 1; i >= 0; i--) begin
              if (diff_any[i]) fidx_nxt = IW'(i);
            end
            pass_nxt   = (diff_any == '0);
            fvalid_nxt = (diff_any != '0);
          end
        end else begin
          cnt_nxt = IW'(cnt + IW'(1));
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt == S_RUN);
    ops_nxt  = (state_nxt == S_RUN) ? idx_nxt : '0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      ops        <= '0;
      exp1       <= '0;
      exp2       <= '0;
      tt_f1      <= '0;
      tt_f2      <= '0;
      err_cnt1   <= '0;
      err_cnt2   <= '0;
      pass       <= 1'b0;
      fail_idx   <= '0;
      fail_valid <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      ops        <= ops_nxt;
      exp1       <= exp1_nxt;
      exp2       <= exp2_nxt;
      tt_f1      <= tt1_nxt;
      tt_f2      <= tt2_nxt;
      err_cnt1   <= err1_nxt;
      err_cnt2   <= err2_nxt;
      pass       <= pass_nxt;
      fail_idx   <= fidx_nxt;
      fail_valid <= fvalid_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
    end
  end

  // Both function units see the same vector, MSB on a/w.
  assign {a_out, b_out, c_out, d_out} = ops;
  assign {w_out, x_out, y_out, z_out} = ops;

endmodule
